ps2_key_rx: RTL and testbench

Front end that turns the raw PS/2 keyboard clock/data lines into the 11-bit `ps2_key` event word consumed by the MSX keyboard matrix logic. It synchronises and de-glitches both lines and deserialises 11-bit device-to-host frames. A prefix state machine folds scan-code set 2 byte sequences (E0, F0, E1) into single make/break events.

---
 rtl/ps2_key_rx_pkg.sv | 37 +++
 rtl/ps2_key_rx_frame.sv | 128 ++++++++++++
 rtl/ps2_key_rx.sv | 135 +++++++++++++
 tb/tb_ps2_key_rx.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_key_rx_pkg.sv
// ----------------------------------------------------------------------------
// ps2_key_rx_pkg
// Shared constants and types for the PS/2 keyboard receiver front end.
//   - scan-code set 2 prefix bytes and the synthesised Pause event
//   - frame length and layout of the 11-bit ps2_key event word
//   - decoder state encoding
// ----------------------------------------------------------------------------
package ps2_key_rx_pkg;

   localparam logic [7:0] PS2_PFX_EXT    = 8'hE0;
   localparam logic [7:0] PS2_PFX_BRK    = 8'hF0;
   localparam logic [7:0] PS2_PFX_PAUSE  = 8'hE1;

   // Pause arrives as E1 14 77 E1 F0 14 F0 77: the E1 emits one event and the
   // remaining seven bytes are swallowed.
   localparam int         PS2_PAUSE_SKIP = 7;
   localparam logic [7:0] PS2_CODE_PAUSE = 8'h77;

   localparam int PS2_FRAME_BITS = 11;

   localparam int PS2_KEY_W   = 11;
   localparam int PS2_KEY_STB = 10;
   localparam int PS2_KEY_BRK = 9;
   localparam int PS2_KEY_EXT = 8;

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_PAUSE = 1'b1
   } dec_state_e;

   // Keyboard status/reply bytes (AA, FA, FE, EE, FF, 00) that must not reach
   // the key matrix when they appear without a prefix.
   function automatic logic is_noise_code(input logic [7:0] code);
      return (code == 8'h00) || (code >= 8'h84);
   endfunction

endpackage

// File: rtl/ps2_key_rx_frame.sv
// ----------------------------------------------------------------------------
// ps2_frame_rx
// Synchronises and de-glitches the raw PS/2 lines and deserialises 11-bit
// device-to-host frames (start, 8 data LSB first, odd parity, stop).
//   clk, reset   system clock, synchronous active-high reset
//   ps2_clk      raw PS/2 clock (asynchronous)
//   ps2_data     raw PS/2 data (asynchronous)
//   byte_valid   one-cycle pulse, rx_byte holds a correctly framed byte
//   rx_byte      last received byte
//   frame_err    one-cycle pulse on parity or stop error
// ----------------------------------------------------------------------------
module ps2_frame_rx
   import ps2_key_rx_pkg::*;
#(
   parameter int FILTER_LEN     = 8,
   parameter int TIMEOUT_CYCLES = 50000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   output logic       byte_valid,
   output logic [7:0] rx_byte,
   output logic       frame_err
);

   localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

   logic            clk_meta_q, clk_sync_q, data_meta_q, data_sync_q;
   logic            filt_q, filt_d;
   logic [7:0]      filt_cnt_q, filt_cnt_d;
   logic [3:0]      bit_cnt_q, bit_cnt_d;
   logic [10:0]     shift_q, shift_d;
   logic [WD_W-1:0] wd_q, wd_d;
   logic            byte_valid_q, byte_valid_d;
   logic [7:0]      byte_q, byte_d;
   logic            frame_err_q, frame_err_d;
   logic            fall;

   always_comb begin
      filt_d       = filt_q;
      filt_cnt_d   = filt_cnt_q;
      bit_cnt_d    = bit_cnt_q;
      shift_d      = shift_q;
      wd_d         = wd_q;
      byte_valid_d = 1'b0;
      byte_d       = byte_q;
      frame_err_d  = 1'b0;
      fall         = 1'b0;

      // The filtered level only moves once the synchronised clock has
      // disagreed with it for FILTER_LEN samples in a row.
      if (clk_sync_q != filt_q) begin
         if (filt_cnt_q == 8'(FILTER_LEN - 1)) begin
            filt_d     = clk_sync_q;
            filt_cnt_d = 8'd0;
            fall       = filt_q;
         end else begin
            filt_cnt_d = filt_cnt_q + 8'd1;
         end
      end else begin
         filt_cnt_d = 8'd0;
      end

      if (fall) begin
         wd_d    = '0;
         shift_d = {data_sync_q, shift_q[10:1]};
         if (bit_cnt_q == 4'd0) begin
            // A high start bit is dropped silently so the receiver resyncs.
            if (!data_sync_q) begin
               bit_cnt_d = 4'd1;
            end
         end else if (bit_cnt_q == 4'(PS2_FRAME_BITS - 1)) begin
            bit_cnt_d = 4'd0;
            // shift_d: [0] start, [8:1] data, [9] parity, [10] stop
            if (shift_d[10] && !shift_d[0] && (^shift_d[9:1])) begin
               byte_valid_d = 1'b1;
               byte_d       = shift_d[8:1];
            end else begin
               frame_err_d = 1'b1;
            end
         end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
         end
      end else if (bit_cnt_q != 4'd0) begin
         // Abandon a stalled frame without flagging an error.
         if (wd_q == WD_W'(TIMEOUT_CYCLES - 1)) begin
            wd_d      = '0;
            bit_cnt_d = 4'd0;
         end else begin
            wd_d = wd_q + WD_W'(1);
         end
      end else begin
         wd_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      clk_meta_q  <= ps2_clk;
      clk_sync_q  <= clk_meta_q;
      data_meta_q <= ps2_data;
      data_sync_q <= data_meta_q;
      if (reset) begin
         filt_q       <= 1'b1;
         filt_cnt_q   <= 8'd0;
         bit_cnt_q    <= 4'd0;
         shift_q      <= '0;
         wd_q         <= '0;
         byte_valid_q <= 1'b0;
         byte_q       <= 8'd0;
         frame_err_q  <= 1'b0;
      end else begin
         filt_q       <= filt_d;
         filt_cnt_q   <= filt_cnt_d;
         bit_cnt_q    <= bit_cnt_d;
         shift_q      <= shift_d;
         wd_q         <= wd_d;
         byte_valid_q <= byte_valid_d;
         byte_q       <= byte_d;
         frame_err_q  <= frame_err_d;
      end
   end

   assign byte_valid = byte_valid_q;
   assign rx_byte    = byte_q;
   assign frame_err  = frame_err_q;

endmodule

// File: rtl/ps2_key_rx.sv
// ----------------------------------------------------------------------------
// ps2_key_rx
// PS/2 keyboard front end producing the 11-bit ps2_key event word.
//   clk, reset   system clock, synchronous active-high reset
//   clk_ena      consumer clock enable; the strobe is issued only when high
//   ps2_clk      raw PS/2 clock
//   ps2_data     raw PS/2 data
//   ps2_key      [10] strobe, [9] break, [8] extended, [7:0] scan code
//   frame_err    one-cycle pulse on a bad frame
// ----------------------------------------------------------------------------
module ps2_key_rx
   import ps2_key_rx_pkg::*;
#(
   parameter int FILTER_LEN     = 8,
   parameter int TIMEOUT_CYCLES = 50000
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 clk_ena,
   input  logic                 ps2_clk,
   input  logic                 ps2_data,
   output logic [PS2_KEY_W-1:0] ps2_key,
   output logic                 frame_err
);

   logic       rx_valid, rx_err;
   logic [7:0] rx_byte;

   ps2_frame_rx #(
      .FILTER_LEN     (FILTER_LEN),
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_frame (
      .clk        (clk),
      .reset      (reset),
      .ps2_clk    (ps2_clk),
      .ps2_data   (ps2_data),
      .byte_valid (rx_valid),
      .rx_byte    (rx_byte),
      .frame_err  (rx_err)
   );

   dec_state_e state_q, state_d;
   logic       ext_q, ext_d, brk_q, brk_d;
   logic [2:0] skip_q, skip_d;
   logic [9:0] key_q, key_d;
   logic       pending_q, pending_d;
   logic       stb_q, stb_d;
   logic       ev_valid;
   logic [9:0] ev_key;

   always_comb begin
      state_d  = state_q;
      ext_d    = ext_q;
      brk_d    = brk_q;
      skip_d   = skip_q;
      ev_valid = 1'b0;
      ev_key   = key_q;

      if (rx_err) begin
         ext_d   = 1'b0;
         brk_d   = 1'b0;
         skip_d  = 3'd0;
         state_d = ST_IDLE;
      end else if (rx_valid) begin
         case (state_q)
            ST_IDLE: begin
               if (rx_byte == PS2_PFX_EXT) begin
                  ext_d = 1'b1;
               end else if (rx_byte == PS2_PFX_BRK) begin
                  brk_d = 1'b1;
               end else if (rx_byte == PS2_PFX_PAUSE) begin
                  ev_valid = 1'b1;
                  ev_key   = {1'b0, 1'b1, PS2_CODE_PAUSE};
                  skip_d   = 3'(PS2_PAUSE_SKIP);
                  ext_d    = 1'b0;
                  brk_d    = 1'b0;
                  state_d  = ST_PAUSE;
               end else if (ext_q || brk_q || !is_noise_code(rx_byte)) begin
                  ev_valid = 1'b1;
                  ev_key   = {brk_q, ext_q, rx_byte};
                  ext_d    = 1'b0;
                  brk_d    = 1'b0;
               end
            end
            ST_PAUSE: begin
               skip_d = skip_q - 3'd1;
               if (skip_q == 3'd1) begin
                  state_d = ST_IDLE;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   // Handshake: the strobe for an earlier event is resolved before a new
   // event re-arms pending, so an overwrite still yields one strobe.
   always_comb begin
      key_d     = key_q;
      pending_d = pending_q;
      stb_d     = 1'b0;
      if (pending_q && clk_ena) begin
         stb_d     = 1'b1;
         pending_d = 1'b0;
      end
      if (ev_valid) begin
         key_d     = ev_key;
         pending_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         ext_q     <= 1'b0;
         brk_q     <= 1'b0;
         skip_q    <= 3'd0;
         key_q     <= 10'd0;
         pending_q <= 1'b0;
         stb_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         ext_q     <= ext_d;
         brk_q     <= brk_d;
         skip_q    <= skip_d;
         key_q     <= key_d;
         pending_q <= pending_d;
         stb_q     <= stb_d;
      end
   end

   assign ps2_key   = {stb_q, key_q};
   assign frame_err = rx_err;

endmodule

// File: tb/tb_ps2_key_rx.sv
module tb_ps2_key_rx;

   localparam int FL   = 4;
   localparam int TO   = 2000;
   localparam int HALF = 25;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        clk_ena = 1'b1;
   logic        ps2_clk = 1'b1;
   logic        ps2_data = 1'b1;
   logic [10:0] ps2_key;
   logic        frame_err;

   always #5 clk = ~clk;

   ps2_key_rx #(
      .FILTER_LEN     (FL),
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .clk_ena   (clk_ena),
      .ps2_clk   (ps2_clk),
      .ps2_data  (ps2_data),
      .ps2_key   (ps2_key),
      .frame_err (frame_err)
   );

   int         tests = 0;
   int         fails = 0;
   logic [9:0] exp_q[$];
   int         strobe_cnt = 0;
   int         err_cnt = 0;
   int         exp_err = 0;
   bit         mon_en = 1'b0;
   bit         prev_stb = 1'b0;
   bit         ena_seen = 1'b0;
   int         ena_mode = 0;
   bit         ena_force = 1'b1;

   // reference model state
   bit m_ext = 1'b0;
   bit m_brk = 1'b0;
   int m_skip = 0;

   always @(posedge clk) begin
      #2;
      clk_ena = (ena_mode == 1) ? 1'($urandom_range(0, 1)) : ena_force;
   end

   // monitor / scoreboard
   always @(negedge clk) begin
      logic [9:0] e;
      if (mon_en) begin
         if (ps2_key[10] === 1'b1) begin
            strobe_cnt++;
            tests++;
            if (exp_q.size() == 0) begin
               fails++;
               $display("FAIL unexpected_strobe: got key %03h, expected no event", ps2_key[9:0]);
            end else begin
               e = exp_q.pop_front();
               if (ps2_key[9:0] !== e || !ena_seen || prev_stb) begin
                  fails++;
                  $display("FAIL event: got key %03h (ena_prev=%0d, prev_stb=%0d), expected %03h with ena_prev=1 prev_stb=0",
                           ps2_key[9:0], ena_seen, prev_stb, e);
               end else begin
                  $display("[TB] event %03h ok", e);
               end
            end
         end
         if (frame_err === 1'b1) err_cnt++;
      end
      prev_stb = (ps2_key[10] === 1'b1);
      ena_seen = (clk_ena === 1'b1);
   end

   task automatic wait_clk(input int n);
      repeat (n) @(posedge clk);
   endtask

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] expv);
      tests++;
      if (got !== expv) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h", name, got, expv);
      end else begin
         $display("[TB] %s = %0h ok", name, got);
      end
   endtask

   task automatic model_byte(input logic [7:0] b);
      if (m_skip > 0) begin
         m_skip--;
      end else if (b == 8'hE0) begin
         m_ext = 1'b1;
      end else if (b == 8'hF0) begin
         m_brk = 1'b1;
      end else if (b == 8'hE1) begin
         exp_q.push_back(10'h177);
         m_ext  = 1'b0;
         m_brk  = 1'b0;
         m_skip = 7;
      end else if (m_ext || m_brk || (b != 8'h00 && b < 8'h84)) begin
         exp_q.push_back({m_brk, m_ext, b});
         m_ext = 1'b0;
         m_brk = 1'b0;
      end
   endtask

   task automatic model_err();
      exp_err++;
      m_ext  = 1'b0;
      m_brk  = 1'b0;
      m_skip = 0;
   endtask

   task automatic send_bits(input logic [10:0] bits, input int nbits, input bit glitch);
      for (int i = 0; i < nbits; i++) begin
         ps2_data = bits[i];
         if (glitch) begin
            wait_clk(HALF / 2);
            ps2_clk = 1'b0;
            wait_clk(FL - 2);
            ps2_clk = 1'b1;
            wait_clk(HALF / 2);
         end else begin
            wait_clk(HALF);
         end
         ps2_clk = 1'b0;
         wait_clk(HALF);
         ps2_clk = 1'b1;
      end
      ps2_data = 1'b1;
   endtask

   task automatic send_frame(input logic [7:0] b, input bit bad, input bit glitch);
      logic p;
      p = (~^b) ^ bad;
      if (bad) model_err();
      else model_byte(b);
      send_bits({1'b1, p, b, 1'b0}, 11, glitch);
      wait_clk(40);
   endtask

   task automatic wait_drain(input string name);
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 200) begin
         @(posedge clk);
         n++;
      end
      tests++;
      if (exp_q.size() != 0) begin
         fails++;
         $display("FAIL %s_drain: %0d events still pending, expected 0", name, exp_q.size());
      end
   endtask

   initial begin
      #950000;
      $display("FAIL global_timeout: simulation did not finish, expected completion");
      $fatal(1, "timeout");
   end

   initial begin
      int s0;
      int e0;
      int r;
      logic [7:0] b;

      wait_clk(6);
      @(negedge clk);
      check("reset_ps2_key", 32'(ps2_key), 32'h0);
      check("reset_frame_err", 32'(frame_err), 32'h0);
      @(posedge clk);
      reset = 1'b0;
      mon_en = 1'b1;
      wait_clk(10);

      // single make code
      s0 = strobe_cnt;
      send_frame(8'h1C, 1'b0, 1'b0);
      wait_drain("make_1C");
      check("make_1C_strobes", 32'(strobe_cnt - s0), 32'd1);
      @(negedge clk);
      check("make_1C_hold", 32'(ps2_key), 32'h01C);

      // break
      s0 = strobe_cnt;
      send_frame(8'hF0, 1'b0, 1'b0);
      check("no_strobe_after_F0", 32'(strobe_cnt - s0), 32'd0);
      send_frame(8'h1C, 1'b0, 1'b0);
      wait_drain("break_1C");
      check("break_1C_strobes", 32'(strobe_cnt - s0), 32'd1);

      // extended break, then plain key
      send_frame(8'hE0, 1'b0, 1'b0);
      send_frame(8'hF0, 1'b0, 1'b0);
      send_frame(8'h7D, 1'b0, 1'b0);
      send_frame(8'h12, 1'b0, 1'b0);
      wait_drain("ext_break");

      // pause sequence
      s0 = strobe_cnt;
      send_frame(8'hE1, 1'b0, 1'b0);
      send_frame(8'h14, 1'b0, 1'b0);
      send_frame(8'h77, 1'b0, 1'b0);
      send_frame(8'hE1, 1'b0, 1'b0);
      send_frame(8'hF0, 1'b0, 1'b0);
      send_frame(8'h14, 1'b0, 1'b0);
      send_frame(8'hF0, 1'b0, 1'b0);
      send_frame(8'h77, 1'b0, 1'b0);
      wait_drain("pause");
      check("pause_strobes", 32'(strobe_cnt - s0), 32'd1);
      send_frame(8'h1C, 1'b0, 1'b0);
      wait_drain("after_pause");

      // parity errors
      s0 = strobe_cnt;
      e0 = err_cnt;
      send_frame(8'h1C, 1'b1, 1'b0);
      check("bad_parity_err", 32'(err_cnt - e0), 32'd1);
      check("bad_parity_strobes", 32'(strobe_cnt - s0), 32'd0);
      send_frame(8'h5A, 1'b0, 1'b0);
      send_frame(8'hE0, 1'b0, 1'b0);
      send_frame(8'h33, 1'b1, 1'b0);
      send_frame(8'h7D, 1'b0, 1'b0);
      wait_drain("after_err");

      // watchdog: partial frame then silence
      send_bits(11'h7FA, 5, 1'b0);
      wait_clk(TO + 500);
      send_frame(8'h29, 1'b0, 1'b0);
      wait_drain("timeout");

      // held-off consumer enable
      ena_force = 1'b0;
      wait_clk(3);
      s0 = strobe_cnt;
      send_frame(8'h29, 1'b0, 1'b0);
      wait_clk(100);
      check("ena_low_strobes", 32'(strobe_cnt - s0), 32'd0);
      @(negedge clk);
      check("ena_low_key", 32'(ps2_key), 32'h029);
      ena_force = 1'b1;
      wait_clk(5);
      check("ena_high_strobes", 32'(strobe_cnt - s0), 32'd1);

      // randomized traffic with clk_ena toggling and clock glitches
      ena_mode = 1;
      for (int i = 0; i < 40; i++) begin
         r = int'($urandom_range(0, 15));
         b = 8'($urandom_range(0, 255));
         case (r)
            0: send_frame(8'hE0, 1'b0, ($urandom_range(0, 3) == 0));
            1: send_frame(8'hF0, 1'b0, ($urandom_range(0, 3) == 0));
            2: send_frame(8'hE1, 1'b0, 1'b0);
            3: send_frame(b, 1'b1, 1'b0);
            default: send_frame(b, 1'b0, ($urandom_range(0, 3) == 0));
         endcase
      end
      ena_mode = 0;
      wait_drain("random");
      check("frame_err_count", 32'(err_cnt), 32'(exp_err));

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
